// File: rtl/alu_operand_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_collector_pkg
// Description : Shared definitions for the ALU operand collector. Holds the
//               sideband (Info) field widths and bit offsets, the packed view
//               of that sideband, the collector entry state encoding and the
//               operand geometry (8 lanes of 32 bits).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_operand_collector_pkg;

  // Operand geometry
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int DATA_W = LANES * LANE_W;

  // Sideband field widths, listed MSB first
  localparam int W_MASK   = 8;
  localparam int W_WARP   = 3;
  localparam int W_INSTR  = 32;
  localparam int W_DST    = 5;
  localparam int W_IMME   = 16;
  localparam int W_ALUOP  = 4;
  localparam int W_SCB    = 2;
  localparam int W_REG    = 5;

  // Sideband field LSB offsets
  localparam int OFF_SCB        = 0;
  localparam int OFF_BLT        = OFF_SCB + W_SCB;
  localparam int OFF_BEQ        = OFF_BLT + 1;
  localparam int OFF_ALUOP      = OFF_BEQ + 1;
  localparam int OFF_REGWRITE   = OFF_ALUOP + W_ALUOP;
  localparam int OFF_IMME_VALID = OFF_REGWRITE + 1;
  localparam int OFF_IMME       = OFF_IMME_VALID + 1;
  localparam int OFF_DST        = OFF_IMME + W_IMME;
  localparam int OFF_INSTR      = OFF_DST + W_DST;
  localparam int OFF_WARP       = OFF_INSTR + W_INSTR;
  localparam int OFF_MASK       = OFF_WARP + W_WARP;
  localparam int INFO_W         = OFF_MASK + W_MASK;

  typedef struct packed {
    logic [W_MASK-1:0]  active_mask;
    logic [W_WARP-1:0]  warp_id;
    logic [W_INSTR-1:0] instr;
    logic [W_DST-1:0]   dst;
    logic [W_IMME-1:0]  imme;
    logic               imme_valid;
    logic               reg_write;
    logic [W_ALUOP-1:0] alu_op;
    logic               beq;
    logic               blt;
    logic [W_SCB-1:0]   scb_id;
  } info_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } entry_state_e;

endpackage
`default_nettype wire

// File: rtl/oc_entry.sv
`default_nettype none
// ============================================================================
// Module      : oc_entry
// Description : One operand collector entry. Holds the instruction sideband,
//               source register numbers, per-source have/in-flight bits, the
//               age bit and the two collected 256-bit operands.
// Ports       : accept/set_older/dispatch  - control from the top arbiter
//               info_in/regs_in            - instruction captured on accept
//               grant                      - per-port grant won by this entry
//               rf_data                    - register file return data
//               idle/complete/req/older    - status to the arbiter
//               info/regs/src1/src2_data   - stored instruction and operands
// Revision    : 1.0 - initial release
// ============================================================================
module oc_entry
  import alu_operand_collector_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                set_older,
  input  logic                dispatch,
  input  logic [INFO_W-1:0]   info_in,
  input  logic [9:0]          regs_in,
  input  logic [1:0]          grant,
  input  logic [2*DATA_W-1:0] rf_data,
  output logic                idle,
  output logic                complete,
  output logic [1:0]          req,
  output logic                older,
  output logic [INFO_W-1:0]   info,
  output logic [9:0]          regs,
  output logic [DATA_W-1:0]   src1_data,
  output logic [DATA_W-1:0]   src2_data
);

  entry_state_e state;
  logic [1:0]   have;
  logic [1:0]   inflight;
  logic         src2_needed;

  // Branches compare two registers, so they read src2 even with an immediate.
  assign src2_needed = ~info_in[OFF_IMME_VALID] | info_in[OFF_BEQ] | info_in[OFF_BLT];

  assign idle     = (state == ST_IDLE);
  assign complete = ~idle & (&have);
  // No re-request while the read for that source is still returning.
  assign req[0]   = (state == ST_COLLECT) & ~have[0] & ~inflight[0];
  assign req[1]   = (state == ST_COLLECT) & ~have[1] & ~inflight[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      have      <= '0;
      inflight  <= '0;
      older     <= 1'b0;
      info      <= '0;
      regs      <= '0;
      src1_data <= '0;
      src2_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_COLLECT;
            info      <= info_in;
            regs      <= regs_in;
            have[0]   <= 1'b0;
            have[1]   <= ~src2_needed;
            inflight  <= '0;
            src2_data <= '0;
          end
        end
        ST_COLLECT: begin
          // A completed entry may dispatch straight from COLLECT when the
          // arbiter picks it; otherwise it parks in READY.
          if (dispatch)
            state <= ST_IDLE;
          else if (&have)
            state <= ST_READY;
        end
        ST_READY: begin
          if (dispatch)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Grant in cycle t, data returns in cycle t+1 and is captured here.
      if (grant[0])
        inflight[0] <= 1'b1;
      if (inflight[0]) begin
        inflight[0] <= 1'b0;
        have[0]     <= 1'b1;
        src1_data   <= rf_data[DATA_W-1:0];
      end
      if (grant[1])
        inflight[1] <= 1'b1;
      if (inflight[1]) begin
        inflight[1] <= 1'b0;
        have[1]     <= 1'b1;
        src2_data   <= rf_data[2*DATA_W-1:DATA_W];
      end

      // A freshly accepted or freed entry is never the older one.
      if (set_older)
        older <= 1'b1;
      if (accept || dispatch)
        older <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_collector
// Description : Two-entry operand collector between issue and the ALU. Accepts
//               ALU/branch instructions, reads up to two source operands over
//               two register file ports (older entry wins conflicts) and
//               dispatches one completed instruction per cycle, oldest first.
// Ports       : Valid_IS_OC/Ready_OC_IS/Info_IS_OC/SrcRegs_IS_OC - issue side
//               RF_Req/RF_Addr/RF_Grant/RF_Data                  - RF ports
//               Valid_OC_ALU and *_OC_ALU fields, Src1/Src2_Data - to the ALU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_collector
  import alu_operand_collector_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                Valid_IS_OC,
  output logic                Ready_OC_IS,
  input  logic [INFO_W-1:0]   Info_IS_OC,
  input  logic [9:0]          SrcRegs_IS_OC,
  output logic [1:0]          RF_Req_OC_RF,
  output logic [15:0]         RF_Addr_OC_RF,
  input  logic [1:0]          RF_Grant_RF_OC,
  input  logic [2*DATA_W-1:0] RF_Data_RF_OC,
  output logic                Valid_OC_ALU,
  output logic [7:0]          ActiveMask_OC_ALU,
  output logic [2:0]          WarpID_OC_ALU,
  output logic [31:0]         Instr_OC_ALU,
  output logic [4:0]          Dst_OC_ALU,
  output logic [15:0]         Imme_OC_ALU,
  output logic                Imme_Valid_OC_ALU,
  output logic                RegWrite_OC_ALU,
  output logic [3:0]          ALUop_OC_ALU,
  output logic                BEQ_OC_ALU,
  output logic                BLT_OC_ALU,
  output logic [1:0]          ScbID_OC_ALU,
  output logic [DATA_W-1:0]   Src1_Data_OC_ALU,
  output logic [DATA_W-1:0]   Src2_Data_OC_ALU
);

  logic [1:0]              idle;
  logic [1:0]              complete;
  logic [1:0]              older;
  logic [1:0]              accept;
  logic [1:0]              set_older;
  logic [1:0]              dispatch;
  logic [1:0][1:0]         req;
  logic [1:0][1:0]         win;
  logic [1:0][INFO_W-1:0]  info;
  logic [1:0][9:0]         regs;
  logic [1:0][DATA_W-1:0]  src1;
  logic [1:0][DATA_W-1:0]  src2;
  info_t                   dsp_info;

  // Entry instances
  for (genvar e = 0; e < 2; e++) begin : g_entry
    oc_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept[e]),
      .set_older (set_older[e]),
      .dispatch  (dispatch[e]),
      .info_in   (Info_IS_OC),
      .regs_in   (SrcRegs_IS_OC),
      .grant     (win[e] & RF_Grant_RF_OC),
      .rf_data   (RF_Data_RF_OC),
      .idle      (idle[e]),
      .complete  (complete[e]),
      .req       (req[e]),
      .older     (older[e]),
      .info      (info[e]),
      .regs      (regs[e]),
      .src1_data (src1[e]),
      .src2_data (src2[e])
    );
  end

  // Accept: judged on state at cycle start, so an entry freed by this edge's
  // dispatch is not reused until the next cycle.
  assign Ready_OC_IS = |idle;

  always_comb begin
    accept = '0;
    if (Valid_IS_OC) begin
      if (idle[0])
        accept[0] = 1'b1;
      else if (idle[1])
        accept[1] = 1'b1;
    end
  end

  assign set_older[0] = accept[1] & ~idle[0];
  assign set_older[1] = accept[0] & ~idle[1];

  // Per-port arbitration: uncontested requests win; on conflict the older
  // entry wins. Only one entry is ever older while both are occupied.
  always_comb begin
    win = '0;
    for (int p = 0; p < 2; p++) begin
      win[0][p] = req[0][p] & (~req[1][p] | older[0]);
      win[1][p] = req[1][p] & (~req[0][p] | older[1]) & ~win[0][p];
    end
  end

  assign RF_Req_OC_RF = win[0] | win[1];

  always_comb begin
    RF_Addr_OC_RF = '0;
    for (int p = 0; p < 2; p++) begin
      if (win[0][p])
        RF_Addr_OC_RF[p*8 +: 8] = {info[0][OFF_WARP +: W_WARP], regs[0][p*W_REG +: W_REG]};
      else if (win[1][p])
        RF_Addr_OC_RF[p*8 +: 8] = {info[1][OFF_WARP +: W_WARP], regs[1][p*W_REG +: W_REG]};
    end
  end

  // Dispatch: oldest completed entry, one per cycle.
  assign dispatch[0] = complete[0] & (~complete[1] | older[0]);
  assign dispatch[1] = complete[1] & ~dispatch[0];

  assign dsp_info = info_t'(dispatch[1] ? info[1] : info[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Valid_OC_ALU      <= 1'b0;
      ActiveMask_OC_ALU <= '0;
      WarpID_OC_ALU     <= '0;
      Instr_OC_ALU      <= '0;
      Dst_OC_ALU        <= '0;
      Imme_OC_ALU       <= '0;
      Imme_Valid_OC_ALU <= 1'b0;
      RegWrite_OC_ALU   <= 1'b0;
      ALUop_OC_ALU      <= '0;
      BEQ_OC_ALU        <= 1'b0;
      BLT_OC_ALU        <= 1'b0;
      ScbID_OC_ALU      <= '0;
      Src1_Data_OC_ALU  <= '0;
      Src2_Data_OC_ALU  <= '0;
    end else begin
      Valid_OC_ALU <= |dispatch;
      if (|dispatch) begin
        ActiveMask_OC_ALU <= dsp_info.active_mask;
        WarpID_OC_ALU     <= dsp_info.warp_id;
        Instr_OC_ALU      <= dsp_info.instr;
        Dst_OC_ALU        <= dsp_info.dst;
        Imme_OC_ALU       <= dsp_info.imme;
        Imme_Valid_OC_ALU <= dsp_info.imme_valid;
        RegWrite_OC_ALU   <= dsp_info.reg_write;
        ALUop_OC_ALU      <= dsp_info.alu_op;
        BEQ_OC_ALU        <= dsp_info.beq;
        BLT_OC_ALU        <= dsp_info.blt;
        ScbID_OC_ALU      <= dsp_info.scb_id;
        Src1_Data_OC_ALU  <= dispatch[1] ? src1[1] : src1[0];
        Src2_Data_OC_ALU  <= dispatch[1] ? src2[1] : src2[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_collector
// Description : Directed self-checking bench for alu_operand_collector with a
//               simple register file responder (grant gated by gnt_en).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_collector;

  logic         clk;
  logic         rst;
  logic         Valid_IS_OC;
  logic         Ready_OC_IS;
  logic [73:0]  Info_IS_OC;
  logic [9:0]   SrcRegs_IS_OC;
  logic [1:0]   RF_Req_OC_RF;
  logic [15:0]  RF_Addr_OC_RF;
  logic [1:0]   RF_Grant_RF_OC;
  logic [511:0] RF_Data_RF_OC;
  logic         Valid_OC_ALU;
  logic [7:0]   ActiveMask_OC_ALU;
  logic [2:0]   WarpID_OC_ALU;
  logic [31:0]  Instr_OC_ALU;
  logic [4:0]   Dst_OC_ALU;
  logic [15:0]  Imme_OC_ALU;
  logic         Imme_Valid_OC_ALU;
  logic         RegWrite_OC_ALU;
  logic [3:0]   ALUop_OC_ALU;
  logic         BEQ_OC_ALU;
  logic         BLT_OC_ALU;
  logic [1:0]   ScbID_OC_ALU;
  logic [255:0] Src1_Data_OC_ALU;
  logic [255:0] Src2_Data_OC_ALU;

  logic [1:0]   gnt_en;
  logic [1:0]   lat_v = 2'b00;
  logic [15:0]  lat_a = 16'h0;

  int errors = 0;
  int checks = 0;

  alu_operand_collector dut (
    .clk               (clk),
    .rst               (rst),
    .Valid_IS_OC       (Valid_IS_OC),
    .Ready_OC_IS       (Ready_OC_IS),
    .Info_IS_OC        (Info_IS_OC),
    .SrcRegs_IS_OC     (SrcRegs_IS_OC),
    .RF_Req_OC_RF      (RF_Req_OC_RF),
    .RF_Addr_OC_RF     (RF_Addr_OC_RF),
    .RF_Grant_RF_OC    (RF_Grant_RF_OC),
    .RF_Data_RF_OC     (RF_Data_RF_OC),
    .Valid_OC_ALU      (Valid_OC_ALU),
    .ActiveMask_OC_ALU (ActiveMask_OC_ALU),
    .WarpID_OC_ALU     (WarpID_OC_ALU),
    .Instr_OC_ALU      (Instr_OC_ALU),
    .Dst_OC_ALU        (Dst_OC_ALU),
    .Imme_OC_ALU       (Imme_OC_ALU),
    .Imme_Valid_OC_ALU (Imme_Valid_OC_ALU),
    .RegWrite_OC_ALU   (RegWrite_OC_ALU),
    .ALUop_OC_ALU      (ALUop_OC_ALU),
    .BEQ_OC_ALU        (BEQ_OC_ALU),
    .BLT_OC_ALU        (BLT_OC_ALU),
    .ScbID_OC_ALU      (ScbID_OC_ALU),
    .Src1_Data_OC_ALU  (Src1_Data_OC_ALU),
    .Src2_Data_OC_ALU  (Src2_Data_OC_ALU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register contents: R1 lane l = l, R2 = 5 everywhere, others tagged.
  function automatic logic [255:0] operand(input logic [2:0] w, input logic [4:0] r);
    logic [255:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      if (r == 5'd1)
        v[l*32 +: 32] = 32'(l);
      else if (r == 5'd2)
        v[l*32 +: 32] = 32'd5;
      else
        v[l*32 +: 32] = {8'hC0, 5'b0, w, 3'b0, r, 8'(l)};
    end
    return v;
  endfunction

  function automatic logic [73:0] mk_info(
    input logic [7:0] mask, input logic [2:0] warp, input logic [31:0] instr,
    input logic [4:0] dst, input logic [15:0] imme, input logic iv, input logic rw,
    input logic [3:0] aluop, input logic beq, input logic blt, input logic [1:0] scb);
    return {mask, warp, instr, dst, imme, iv, rw, aluop, beq, blt, scb};
  endfunction

  // Register file responder: same-cycle grant, data the following cycle.
  assign RF_Grant_RF_OC = RF_Req_OC_RF & gnt_en;
  always @(posedge clk) begin
    lat_v <= RF_Grant_RF_OC;
    lat_a <= RF_Addr_OC_RF;
  end
  always_comb begin
    RF_Data_RF_OC = '0;
    for (int p = 0; p < 2; p++)
      RF_Data_RF_OC[p*256 +: 256] = lat_v[p] ? operand(lat_a[p*8+5 +: 3], lat_a[p*8 +: 5])
                                             : {8{32'hDEADBEEF}};
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; returns one step after the edge.
  task automatic issue(input logic [73:0] info, input logic [4:0] s1, input logic [4:0] s2);
    Valid_IS_OC   = 1'b1;
    Info_IS_OC    = info;
    SrcRegs_IS_OC = {s2, s1};
    tick();
    Valid_IS_OC   = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (Valid_OC_ALU !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 256'(Valid_OC_ALU), 256'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic found;
    rst = 1'b0; Valid_IS_OC = 1'b0; Info_IS_OC = '0; SrcRegs_IS_OC = '0; gnt_en = 2'b11;
    repeat (3) tick();
    check("rst ready", 256'(Ready_OC_IS), 256'd1);
    check("rst valid", 256'(Valid_OC_ALU), 256'd0);
    check("rst req", 256'(RF_Req_OC_RF), 256'd0);
    check("rst src1", Src1_Data_OC_ALU, 256'd0);
    check("rst imme", 256'(Imme_OC_ALU), 256'd0);
    rst = 1'b1;
    check("post-rst ready", 256'(Ready_OC_IS), 256'd1);
    tick();

    // Single ADD, immediate grants: minimum latency.
    issue(mk_info(8'hFF, 3'd0, 32'h002081B3, 5'd3, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1), 5'd1, 5'd2);
    check("add req c1", 256'(RF_Req_OC_RF), 256'd3);
    check("add addr c1", 256'(RF_Addr_OC_RF), 256'h0201);
    tick();
    check("add no rereq c2", 256'(RF_Req_OC_RF), 256'd0);
    tick();
    check("add valid c3", 256'(Valid_OC_ALU), 256'd0);
    tick();
    check("add valid c4", 256'(Valid_OC_ALU), 256'd1);
    check("add src1", Src1_Data_OC_ALU, operand(3'd0, 5'd1));
    check("add src2", Src2_Data_OC_ALU, {8{32'd5}});
    check("add dst", 256'(Dst_OC_ALU), 256'd3);
    check("add regwrite", 256'(RegWrite_OC_ALU), 256'd1);
    check("add scb", 256'(ScbID_OC_ALU), 256'd1);
    check("add mask", 256'(ActiveMask_OC_ALU), 256'hFF);
    tick();
    check("add valid c5", 256'(Valid_OC_ALU), 256'd0);
    check("add src1 hold", Src1_Data_OC_ALU, operand(3'd0, 5'd1));

    // ADDI: only port0 is read, src2 forced to zero.
    issue(mk_info(8'hFF, 3'd3, 32'h00108093, 5'd4, 16'hFFFF, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0), 5'd1, 5'd9);
    check("addi req", 256'(RF_Req_OC_RF), 256'd1);
    check("addi addr", 256'(RF_Addr_OC_RF), 256'h0061);
    repeat (3) tick();
    check("addi valid c4", 256'(Valid_OC_ALU), 256'd1);
    check("addi src2 zero", Src2_Data_OC_ALU, 256'd0);
    check("addi imme", 256'(Imme_OC_ALU), 256'hFFFF);
    check("addi imme_valid", 256'(Imme_Valid_OC_ALU), 256'd1);
    check("addi src1", Src1_Data_OC_ALU, operand(3'd3, 5'd1));
    tick();

    // Same register on both sources: both ports still read.
    issue(mk_info(8'h0F, 3'd1, 32'h00210133, 5'd2, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd3), 5'd2, 5'd2);
    check("same req", 256'(RF_Req_OC_RF), 256'd3);
    check("same addr", 256'(RF_Addr_OC_RF), 256'h2222);
    wait_valid(10, "same");
    check("same src1", Src1_Data_OC_ALU, operand(3'd1, 5'd2));
    check("same src2", Src2_Data_OC_ALU, operand(3'd1, 5'd2));
    tick();

    // Back-to-back, port1 withheld three cycles: older still dispatches first.
    gnt_en = 2'b01;
    issue(mk_info(8'hFF, 3'd1, 32'h11111111, 5'd7, 16'h0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0), 5'd3, 5'd4);
    check("b2b req c1", 256'(RF_Req_OC_RF), 256'd3);
    issue(mk_info(8'hFF, 3'd2, 32'h22222222, 5'd8, 16'h0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 2'd1), 5'd5, 5'd6);
    check("b2b older wins p1", 256'(RF_Addr_OC_RF[15:8]), 256'h24);
    check("b2b younger p0", 256'(RF_Addr_OC_RF[7:0]), 256'h45);
    tick();
    tick();
    gnt_en = 2'b11;
    wait_valid(20, "b2b first");
    check("b2b first warp", 256'(WarpID_OC_ALU), 256'd1);
    check("b2b first src1", Src1_Data_OC_ALU, operand(3'd1, 5'd3));
    check("b2b first src2", Src2_Data_OC_ALU, operand(3'd1, 5'd4));
    tick();
    check("b2b second valid", 256'(Valid_OC_ALU), 256'd1);
    check("b2b second warp", 256'(WarpID_OC_ALU), 256'd2);
    check("b2b second src1", Src1_Data_OC_ALU, operand(3'd2, 5'd5));
    check("b2b second src2", Src2_Data_OC_ALU, operand(3'd2, 5'd6));
    tick();
    check("b2b idle after", 256'(Valid_OC_ALU), 256'd0);

    // Both entries full, third instruction held until a slot frees.
    gnt_en = 2'b00;
    issue(mk_info(8'hFF, 3'd4, 32'h33333333, 5'd1, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0), 5'd10, 5'd11);
    issue(mk_info(8'hFF, 3'd6, 32'h44444444, 5'd2, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1), 5'd12, 5'd13);
    Valid_IS_OC   = 1'b1;
    Info_IS_OC    = mk_info(8'hAA, 3'd7, 32'h55555555, 5'd9, 16'h0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 2'd2);
    SrcRegs_IS_OC = {5'd2, 5'd1};
    check("full ready c2", 256'(Ready_OC_IS), 256'd0);
    tick();
    gnt_en = 2'b11;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (Valid_OC_ALU === 1'b1) begin
        found = 1'b1;
        check("full ready after dispatch", 256'(Ready_OC_IS), 256'd1);
        check("full first warp", 256'(WarpID_OC_ALU), 256'd4);
      end else begin
        check("full ready held", 256'(Ready_OC_IS), 256'd0);
        tick();
      end
    end
    check("full dispatch seen", 256'(found), 256'd1);
    tick();
    Valid_IS_OC = 1'b0;
    check("full second warp", 256'(WarpID_OC_ALU), 256'd6);
    check("full second src2", Src2_Data_OC_ALU, operand(3'd6, 5'd13));
    tick();
    check("full gap", 256'(Valid_OC_ALU), 256'd0);
    wait_valid(20, "full third");
    check("full third warp", 256'(WarpID_OC_ALU), 256'd7);
    check("full third dst", 256'(Dst_OC_ALU), 256'd9);
    check("full third src1", Src1_Data_OC_ALU, operand(3'd7, 5'd1));
    tick();

    // Reset in the cycle after a grant: late data must be dropped.
    issue(mk_info(8'hFF, 3'd2, 32'h66666666, 5'd5, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0), 5'd1, 5'd2);
    tick();
    rst = 1'b0;
    #1;
    check("mid rst req", 256'(RF_Req_OC_RF), 256'd0);
    check("mid rst valid", 256'(Valid_OC_ALU), 256'd0);
    check("mid rst src1 zero", Src1_Data_OC_ALU, 256'd0);
    check("mid rst warp zero", 256'(WarpID_OC_ALU), 256'd0);
    #2;
    rst = 1'b1;
    tick();
    check("after rst ready", 256'(Ready_OC_IS), 256'd1);
    check("after rst req", 256'(RF_Req_OC_RF), 256'd0);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      if (Valid_OC_ALU === 1'b1) seen++;
      tick();
    end
    check("after rst no dispatch", 256'(seen), 256'd0);
    issue(mk_info(8'hFF, 3'd5, 32'h77777777, 5'd6, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd0), 5'd2, 5'd1);
    wait_valid(10, "post rst");
    check("post rst src1", Src1_Data_OC_ALU, operand(3'd5, 5'd2));
    check("post rst src2", Src2_Data_OC_ALU, operand(3'd5, 5'd1));
    tick();

    // BEQ with an immediate still reads both sources.
    issue(mk_info(8'h0F, 3'd5, 32'h00838463, 5'd0, 16'h0010, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 2'd2), 5'd7, 5'd8);
    check("beq req", 256'(RF_Req_OC_RF), 256'd3);
    check("beq addr", 256'(RF_Addr_OC_RF), 256'hA8A7);
    repeat (3) tick();
    check("beq valid c4", 256'(Valid_OC_ALU), 256'd1);
    check("beq flag", 256'(BEQ_OC_ALU), 256'd1);
    check("beq blt", 256'(BLT_OC_ALU), 256'd0);
    check("beq scb", 256'(ScbID_OC_ALU), 256'd2);
    check("beq warp", 256'(WarpID_OC_ALU), 256'd5);
    check("beq src2", Src2_Data_OC_ALU, operand(3'd5, 5'd8));
    check("beq mask", 256'(ActiveMask_OC_ALU), 256'h0F);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 Valid_IS_OC  input  1  issue stage presents an ALU/branch instruction.
REQ-004 Ready_OC_IS  output  1  at least one collector entry is IDLE; handshake = Valid_IS_OC & Ready_OC_IS at rising edge.
REQ-005 Info_IS_OC  input  74  packed sideband, layout per package: ActiveMask 8, WarpID 3, Instr 32, Dst 5, Imme 16, Imme_Valid 1, RegWrite 1, ALUop 4, BEQ 1, BLT 1, ScbID 2.
REQ-006 SrcRegs_IS_OC  input  10  {Src2[4:0], Src1[4:0]} register numbers.
REQ-007 RF_Req_OC_RF  output  2  bit0 = src1 read port request, bit1 = src2 read port request.
REQ-008 RF_Addr_OC_RF  output  16  per port {WarpID, Reg}; port0 in [7:0], port1 in [15:8].
REQ-009 RF_Grant_RF_OC  input  2  same-cycle grant per port.
REQ-010 RF_Data_RF_OC  input  512  port0 data [255:0], port1 data [511:256]; valid the cycle after grant.
REQ-011 Valid_OC_ALU  output  1  registered dispatch strobe; ALU never stalls.
REQ-012 ActiveMask/WarpID/Instr/Dst/Imme/Imme_Valid/RegWrite/ALUop/BEQ/BLT/ScbID_OC_ALU  output  8/3/32/5/16/1/1/4/1/1/2  registered fields of the dispatched instruction, one port each.
REQ-013 Src1_Data_OC_ALU, Src2_Data_OC_ALU  output  256 each  registered 8-lane operands.

Function
REQ-014 Two collector entries (E0, E1), each with states IDLE, COLLECT, READY, plus a have-bit per source and an age bit.
REQ-015 Accept only into an entry IDLE at cycle start, choosing the lowest-index IDLE entry; the accepted entry enters COLLECT, sets the age bit to younger, and marks the other valid entry older.
REQ-016 On accept, the src1 have-bit clears; the src2 have-bit clears unless Imme_Valid=1 (no src2 read, Src2_Data driven 0); BEQ/BLT always read both sources.
REQ-017 A COLLECT entry with a missing source requests that source's port; when both entries request the same port, the older wins, and only the winner's address is driven.
REQ-018 Grant in cycle t: RF_Data captured at the edge ending cycle t+1 and the have-bit set; no re-request while a read is in flight.
REQ-019 With all have-bits set, the entry becomes READY at the following edge.
REQ-020 One dispatch per cycle: the oldest READY entry loads the output registers, Valid_OC_ALU=1 the next cycle, and the entry returns to IDLE at the same edge; with no READY entry, Valid_OC_ALU=0 and the data registers hold.
REQ-021 A freed entry is not reusable by an accept in the same edge; Ready_OC_IS reflects it from the next cycle.
REQ-022 Minimum latency: accept edge E0 -> request cycle 1 -> data captured E2 -> READY E3 -> Valid_OC_ALU high in cycle 4.
REQ-023 Src1==Src2 register: both ports still read independently.
REQ-024 Both entries full: Ready_OC_IS=0, and Valid_IS_OC is ignored.

Reset
REQ-025 Asserting rst, including mid-collection, forces entries IDLE, clears have-bits, ages and in-flight flags, drives RF_Req=0 and Valid_OC_ALU=0, and zeroes all ALU output registers; RF data returning after release is discarded.
REQ-026 Ready_OC_IS=1 in the first cycle after rst deasserts.

Structure
REQ-027 A shared package holds the Info field widths/offsets, entry state enum, lane count 8 and lane width 32.
REQ-028 One sub-module, oc_entry (state, have-bits, operand storage); arbitration and dispatch stay in the top module.

Verification
REQ-029 Single ADD, all grants immediate, R1=lane*1, R2=5 -> Valid_OC_ALU in cycle 4, Src1 lanes 0..7, Src2 all 5.
REQ-030 ADDI Imme_Valid=1, Imme=0xFFFF -> only port0 requested, Src2_Data=0, Imme_OC_ALU=0xFFFF.
REQ-031 Two back-to-back issues, port1 grant withheld 3 cycles for the older -> older still dispatches first, younger the next cycle, with no lost data.
REQ-032 Both entries full, third Valid_IS_OC held -> Ready_OC_IS=0 until the cycle after the first dispatch, then accepted.
REQ-033 rst asserted the cycle after a grant -> no dispatch, the late RF_Data is ignored, and Ready_OC_IS=1 after release.
REQ-034 BEQ with ScbID=2, WarpID=5 -> both ports read, and dispatch carries BEQ=1, ScbID=2, WarpID=5.
